phy_rx_lanes: RTL



---
 rtl/phy_pkg.sv | 22 ++
 rtl/phy_lane_sp.sv | 76 +++++++
 rtl/phy_rx_lanes.sv | 85 ++++++++
 3 files changed

// File: rtl/phy_pkg.sv
// Shared types and helpers for the multi-lane PHY receiver.
// Lane alignment states, default comma symbol and a clog2 helper.
package phy_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    COUNT  = 2'd1,
    ACTIVE = 2'd2
  } lane_st_t;

  localparam logic [7:0] COMMA_DEF = 8'hBC;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/phy_lane_sp.sv
// One serial lane: MSB-first deserialiser, comma alignment FSM
// and word holding register with a word-boundary load strobe.
module phy_lane_sp
  import phy_pkg::*;
#(
  parameter int             WIDTH     = 8,
  parameter logic [WIDTH-1:0] COMMA   = COMMA_DEF,
  parameter int             ALIGN_CNT = 4
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic             bit_in,
  output logic             active,
  output logic             load,
  output logic [WIDTH-1:0] word
);

  localparam int BW0 = clog2(WIDTH);
  localparam int BW  = (BW0 < 1) ? 1 : BW0;
  localparam int CW0 = clog2(ALIGN_CNT + 1);
  localparam int CW  = (CW0 < 1) ? 1 : CW0;

  lane_st_t         st;
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic [BW-1:0]    bcnt;
  logic [CW-1:0]    ccnt;
  logic             bnd;
  logic             is_comma;

  // Comparisons include the bit being sampled on this edge.
  assign sr_nxt   = {sr, bit_in};
  assign bnd      = (bcnt == BW'(WIDTH - 1));
  assign is_comma = (sr_nxt == COMMA);

  assign active = (st == ACTIVE);
  assign load   = active && bnd;

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      st   <= SEARCH;
      sr   <= '0;
      bcnt <= '0;
      ccnt <= '0;
      word <= '0;
    end else begin
      sr   <= sr_nxt[WIDTH-2:0];
      bcnt <= bnd ? '0 : bcnt + 1'b1;
      unique case (st)
        SEARCH: begin
          if (is_comma) begin
            bcnt <= '0;
            ccnt <= CW'(1);
            st   <= COUNT;
          end
        end
        COUNT: begin
          if (bnd) begin
            if (is_comma) begin
              ccnt <= ccnt + 1'b1;
              if (ccnt == CW'(ALIGN_CNT - 1)) st <= ACTIVE;
            end else begin
              ccnt <= '0;
              st   <= SEARCH;
            end
          end
        end
        ACTIVE: begin
          if (bnd) word <= sr_nxt;
        end
        default: st <= SEARCH;
      endcase
    end
  end

endmodule

// File: rtl/phy_rx_lanes.sv
// N-lane PHY receiver: per-lane alignment plus a round-robin
// unstriper merging active lanes into one word stream.
module phy_rx_lanes
  import phy_pkg::*;
#(
  parameter int               LANES     = 2,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] COMMA     = COMMA_DEF,
  parameter int               ALIGN_CNT = 4
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic [LANES-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic [LANES-1:0] active_out,
  output logic             overrun_out
);

  localparam int PW0 = clog2(LANES);
  localparam int PW  = (PW0 < 1) ? 1 : PW0;

  logic [LANES-1:0] act;
  logic [LANES-1:0] load;
  logic [LANES-1:0] full;
  logic [LANES-1:0] take;
  logic [WIDTH-1:0] hold [LANES];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_nxt;
  logic             all_act;
  logic [WIDTH-1:0] cur;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    phy_lane_sp #(
      .WIDTH    (WIDTH),
      .COMMA    (COMMA),
      .ALIGN_CNT(ALIGN_CNT)
    ) u_lane (
      .clk_8f(clk_8f),
      .reset (reset),
      .bit_in(data_in[g]),
      .active(act[g]),
      .load  (load[g]),
      .word  (hold[g])
    );
  end

  assign active_out = act;
  assign all_act    = &act;
  assign cur        = hold[ptr];
  assign ptr_nxt    = (ptr == PW'(LANES - 1)) ? '0 : ptr + 1'b1;

  always_comb begin
    take = '0;
    if (all_act && full[ptr]) take[ptr] = 1'b1;
  end

  // Until every lane is aligned, loads are dropped and ptr parks at 0.
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      full        <= '0;
      ptr         <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (!all_act) begin
        full <= '0;
        ptr  <= '0;
      end else begin
        full <= (full & ~take) | load;
        if (|(load & full & ~take)) overrun_out <= 1'b1;
        if (|take) begin
          ptr <= ptr_nxt;
          if (cur != COMMA) begin
            data_out  <= cur;
            valid_out <= 1'b1;
          end
        end
      end
    end
  end

endmodule
